// File: rtl/seg_display_mux.sv
// seg_display_mux: multiplexed seven-segment driver for DIGITS digits.
// The value is latched in hex or decimal mode. Decimal mode runs a
// sequential double-dabble converter behind a load/busy handshake.
// The display buffer is written in one step, so a partial conversion
// is never shown.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_mux #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 12000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic                decimal,
  input  logic [DIGITS-1:0]   dp,
  input  logic                load,
  output logic                busy,
  output logic                overflow,
  output logic [6:0]          seven_segment,
  output logic                seven_segment_dp,
  output logic [DIGITS-1:0]   seven_segment_select
);

  localparam int W    = 4 * DIGITS;
  localparam int BW   = W + 4;
  localparam int CNTW = $clog2(W);
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t            state, state_next;
  logic [W-1:0]      shift_q;
  logic [BW-1:0]     bcd_q, bcd_adj, bcd_next;
  logic              lost_q, lost_next;
  logic [CNTW-1:0]   iter_q;
  logic              last_iter, conv_ovf;
  logic [DIGITS-1:0] dp_pend_q;
  logic [W-1:0]      buf_q;
  logic [DIGITS-1:0] dp_q;
  logic              overflow_q;
  logic [DIVW-1:0]   div_q;
  logic [IDXW-1:0]   idx_q;
  logic [3:0]        digit;
  logic              blank;
  logic [6:0]        glyph;

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  assign busy     = (state == CONVERT);
  assign overflow = overflow_q;

  // One double-dabble step; bits pushed out of the top nibble are remembered as overflow
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next  = {bcd_adj[BW-2:0], shift_q[W-1]};
    lost_next = lost_q | bcd_adj[BW-1];
    last_iter = (iter_q == CNTW'(W - 1));
    conv_ovf  = lost_next | (bcd_next[BW-1 -: 4] != 4'd0);
  end

  // Converter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: a decimal load starts conversion, the final iteration returns to idle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load && decimal) state_next = CONVERT;
      CONVERT: if (last_iter)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load capture, conversion datapath and atomic buffer write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      lost_q     <= 1'b0;
      iter_q     <= '0;
      dp_pend_q  <= '0;
      buf_q      <= '0;
      dp_q       <= '0;
      overflow_q <= 1'b0;
    end else if (state == IDLE) begin
      if (load && !decimal) begin
        buf_q      <= value;
        dp_q       <= dp;
        overflow_q <= 1'b0;
      end else if (load) begin
        shift_q   <= value;
        bcd_q     <= '0;
        lost_q    <= 1'b0;
        iter_q    <= '0;
        dp_pend_q <= dp;
      end
    end else begin
      shift_q <= shift_q << 1;
      bcd_q   <= bcd_next;
      lost_q  <= lost_next;
      iter_q  <= iter_q + 1'b1;
      if (last_iter) begin
        dp_q       <= dp_pend_q;
        overflow_q <= conv_ovf;
        if (!conv_ovf) buf_q <= bcd_next[W-1:0];
      end
    end
  end

  // Scan divider and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIVW'(CLK_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zero_above;
`endif

  // Glyph for the active digit: dash on overflow, optional leading-zero blank
  always_comb begin
    digit = buf_q[4*idx_q +: 4];
    blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    zero_above = '0;
    zero_above[DIGITS-1] = (buf_q[W-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (buf_q[4*i +: 4] == 4'd0);
    end
    blank = (idx_q != '0) && zero_above[idx_q];
`else
    blank = 1'b0;
`endif
    if (overflow_q)  glyph = 7'h40;
    else if (blank)  glyph = 7'h00;
    else             glyph = hex_glyph(digit);
  end

  // Registered pins with polarity; select is inactive while the divider is 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seven_segment        <= SEG_OFF;
      seven_segment_dp     <= DP_OFF;
      seven_segment_select <= SEL_OFF;
    end else begin
      seven_segment    <= (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
      seven_segment_dp <= (SEG_ACTIVE_LOW != 0) ? ~dp_q[idx_q] : dp_q[idx_q];
      if (div_q == '0)
        seven_segment_select <= SEL_OFF;
      else
        seven_segment_select <= (SEL_ACTIVE_LOW != 0) ? ~(DIGITS'(1) << idx_q) : (DIGITS'(1) << idx_q);
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed bench for seg_display_mux with DIGITS=4, CLK_DIV=4,
// active-low segments and selects. Honours SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        decimal = 1'b0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        busy, overflow, seg_dp;
  logic [6:0]  seg;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;
  int n;
  logic [6:0] lead;
  logic [3:0] exp_sel [6] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};

  seg_display_mux #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .decimal(decimal), .dp(dp), .load(load),
    .busy(busy), .overflow(overflow), .seven_segment(seg), .seven_segment_dp(seg_dp),
    .seven_segment_select(sel)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] v, input logic dec, input logic [3:0] p);
    @(negedge clk);
    value = v; decimal = dec; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic read_digit(input int d, output logic [6:0] s, output logic p);
    logic       found;
    logic [3:0] want;
    found = 1'b0;
    want  = ~(4'b0001 << d);
    s = 'x;
    p = 1'bx;
    @(negedge clk);
    for (int k = 0; k < 40 && !found; k++) begin
      if (sel === want) begin
        found = 1'b1;
        s = seg;
        p = seg_dp;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) $display("[TB] digit %0d select never seen", d);
  endtask

  task automatic check_digit(input string tag, input int d, input logic [6:0] exp_seg, input logic exp_dp);
    logic [6:0] s;
    logic       p;
    read_digit(d, s, p);
    check_output({tag, "_seg"}, {9'd0, s}, {9'd0, exp_seg});
    check_output({tag, "_dp"}, {15'd0, p}, {15'd0, exp_dp});
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lead = 7'h7F;
`else
    lead = 7'h40;
`endif
    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    check_output("rst_seg", {9'd0, seg}, 16'h007F);
    check_output("rst_dp", {15'd0, seg_dp}, 16'h0001);
    check_output("rst_sel", {12'd0, sel}, 16'h000F);
    check_output("rst_busy", {15'd0, busy}, 16'h0000);
    check_output("rst_ovf", {15'd0, overflow}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output($sformatf("scan_sel%0d", i), {12'd0, sel}, {12'd0, exp_sel[i]});
    end

    $display("[TB] hex load BEEF");
    apply_stimulus(16'hBEEF, 1'b0, 4'b0100);
    check_output("hex_busy", {15'd0, busy}, 16'h0000);
    check_digit("hex_d0", 0, 7'h0E, 1'b1);
    check_digit("hex_d1", 1, 7'h06, 1'b1);
    check_digit("hex_d2", 2, 7'h06, 1'b0);
    check_digit("hex_d3", 3, 7'h03, 1'b1);

    $display("[TB] decimal load 1234 with ignored 9999");
    @(negedge clk);
    value = 16'd1234; decimal = 1'b1; dp = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 3) begin
        value = 16'd9999;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check_output("dec_busy_cycles", n[15:0], 16'd16);
    check_output("dec_ovf", {15'd0, overflow}, 16'h0000);
    check_digit("dec_d0", 0, 7'h19, 1'b1);
    check_digit("dec_d1", 1, 7'h30, 1'b1);
    check_digit("dec_d2", 2, 7'h24, 1'b1);
    check_digit("dec_d3", 3, 7'h79, 1'b1);

    $display("[TB] decimal overflow 10000");
    apply_stimulus(16'd10000, 1'b1, 4'b0000);
    wait_idle(n);
    check_output("ovf_busy_cycles", n[15:0], 16'd16);
    check_output("ovf_flag", {15'd0, overflow}, 16'h0001);
    check_digit("ovf_d0", 0, 7'h3F, 1'b1);
    check_digit("ovf_d3", 3, 7'h3F, 1'b1);

    $display("[TB] hex load 0005 clears overflow");
    apply_stimulus(16'h0005, 1'b0, 4'b0000);
    check_output("hex5_ovf", {15'd0, overflow}, 16'h0000);
    check_digit("hex5_d0", 0, 7'h12, 1'b1);
    check_digit("hex5_d1", 1, lead, 1'b1);
    check_digit("hex5_d3", 3, lead, 1'b1);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    $display("[TB] hex load 0000 with dp on digit 1");
    apply_stimulus(16'h0000, 1'b0, 4'b0010);
    check_digit("zero_d0", 0, 7'h40, 1'b1);
    check_digit("zero_d1", 1, 7'h7F, 1'b0);
    check_digit("zero_d2", 2, 7'h7F, 1'b1);
`endif

    $display("[TB] reset in the middle of a 4321 conversion");
    apply_stimulus(16'd4321, 1'b1, 4'b1111);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("mid_busy", {15'd0, busy}, 16'h0000);
    check_output("mid_ovf", {15'd0, overflow}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("mid_busy_after", {15'd0, busy}, 16'h0000);
    check_digit("mid_d0", 0, 7'h40, 1'b1);
    check_digit("mid_d1", 1, lead, 1'b1);
    check_digit("mid_d2", 2, lead, 1'b1);
    check_digit("mid_d3", 3, lead, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Parametrised multiplexed seven-segment driver, the next generation of the board's 4-digit display driver. It drives `DIGITS` common-select digits from a latched value in either hex or decimal mode, with per-digit decimal points and an overflow indication. Decimal mode uses a sequential binary-to-BCD converter (double-dabble) with a load/busy handshake. The display buffer updates atomically, so the display never shows a partially converted value. It sits between application counters/registers in `top` and the board pins.

## Interface

Parameters:
- `DIGITS`, 4: number of digits; value width `W = 4*DIGITS`.
- `CLK_DIV`, 12000: clock cycles per digit slot; minimum 2.
- `SEG_ACTIVE_LOW`, 1: segment and decimal-point pins are active-low when 1.
- `SEL_ACTIVE_LOW`, 1: digit select pins are active-low when 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  W  binary value, sampled on `load`.
- `decimal`  in  1  mode, sampled on `load`: 1 = decimal, 0 = hex.
- `dp`  in  DIGITS  decimal-point enables, sampled on `load`; bit i controls digit i.
- `load`  in  1  single-cycle request to capture `value`, `decimal` and `dp`.
- `busy`  out  1  high while a decimal conversion is running.
- `overflow`  out  1  set when the last decimal load exceeded `10^DIGITS-1`.
- `seven_segment`  out  7  segments; bit 0 = a through bit 6 = g.
- `seven_segment_dp`  out  1  decimal point of the active digit.
- `seven_segment_select`  out  DIGITS  one-hot digit select; bit 0 = least significant digit.

## Operation

- **Load acceptance:** `load` is accepted only when `busy=0`. A `load` while `busy=1` is ignored; there is no queueing.
- **Hex load:** the buffer takes `value` nibbles directly. `dp` is latched and `overflow` clears. `busy` is never asserted.
- **Decimal load:** the inputs are captured into a shift register. `busy` rises and the FSM runs IDLE -> CONVERT -> IDLE.
  - CONVERT performs W iterations, one per cycle: add 3 to each BCD nibble that is >=5, then shift left by 1.
  - BCD register width is 4*DIGITS + 4 bits; the extra top nibble detects overflow.
  - On completion, if the top nibble or any BCD nibble is nonzero beyond DIGITS digits (i.e. value > `10^DIGITS-1`), `overflow` is set and every digit shows a dash (glyph 7'h40).
  - Otherwise the DIGITS BCD nibbles are written to the buffer and `overflow` clears.
  - `dp` is written to the buffer together with the digits.
- **Scan divider:** counts 0..CLK_DIV-1. On wrap, the digit index advances 0 -> 1 -> ... -> DIGITS-1 -> 0.
- **Anti-ghosting:** while the divider is 0, select is all-inactive.
- **Glyphs (logical, before polarity):** 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71, dash 40, blank 00.
- **Polarity:** applied at the output registers per `SEG_ACTIVE_LOW` / `SEL_ACTIVE_LOW`.

## Timing

- **Reset values:** divider 0, digit index 0, buffer all zero, dp all zero, `busy=0`, `overflow=0`, FSM IDLE. Segments and dp are all off (7'h7F and 1 with active-low). Select is all inactive.
- **Reset mid-conversion:** aborts the conversion. The buffer returns to zero and no partial result is ever written.
- **Hex latency:** buffer updated at the first edge after the `load` edge.
- **Decimal latency:**
  - `busy` is high for exactly W cycles, starting the cycle after `load`.
  - Buffer and `overflow` update on the same edge on which `busy` falls.
  - A new `load` is accepted in the first cycle where `busy=0`.
- **Output timing:**
  - All pin outputs are registered: one cycle from the buffer/index to the pins.
  - A buffer update mid-slot is visible from the next cycle.

## Configuration

- Macro `SEG_LEADING_ZERO_BLANK_EN`.
- **Defined:** zero digits above the highest nonzero digit show blank (00). Digit 0 is never blanked. Their dp still displays if set. Applies in hex and decimal modes; does not apply to dash overflow display.
- **Undefined:** every digit always shows its glyph, including leading zeros.

## Test plan

All scenarios use DIGITS=4, CLK_DIV=4, both active-low.

- **Reset:** hold `rst_n=0` -> `seven_segment=7'h7F`, `seven_segment_dp=1`, select 4'hF, `busy=0`, `overflow=0`. Deassert -> select cycles 4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD...
- **Hex load:** `load` with `value=16'hBEEF`, `decimal=0`, `dp=4'b0100` -> one cycle later slots show digit0 F (~71), digit1 E, digit2 E with dp low, digit3 b (~7C); `busy` stays 0.
- **Decimal load:** `load` with `value=16'd1234`, `decimal=1` -> `busy` high exactly 16 cycles. A second `load` with `16'd9999` during `busy` is ignored. Digits then show 4,3,2,1 and `overflow=0`.
- **Decimal overflow:** `load` with `value=16'd10000`, `decimal=1` -> after 16 cycles `overflow=1` and all digits show `~7'h40`. A following hex load clears `overflow`.
- **Reset mid-conversion:** pulse `rst_n` low at cycle 8 of a `16'd4321` decimal conversion -> `busy=0` and buffer zero. No digit ever shows 4321 or any partial value.
- **Leading-zero blanking (`SEG_LEADING_ZERO_BLANK_EN` defined):** hex `16'h0005` -> digits 3..1 blank (7'h7F), digit0 `~6D`. Value 0 -> only digit0 shows `~3F`.
